mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Owns the 16 x 8-bit unified program/data memory and shares it between two requesters.
- Port 0 is the CPU core (fetch, operand read and execute-phase write). Port 1 is the program loader/debug port.
- Round-robin arbitration, one access per cycle, with a bounded lock so the core's read-modify-write opcodes (double-in-place, complement-in-place) run without interleaving.
- Sits between the CPU sequencer and the memory array; the core no longer indexes memory directly.

Parameters:
- ADDR_W, 4, address width.
- DATA_W, 8, word width.
- DEPTH, 16, number of words (2**ADDR_W).
- MAX_LOCK, 4, maximum consecutive cycles a lock may be held before forced release.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 access request.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- lock0  in  1  port 0 keeps ownership after this access.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 access accepted this cycle.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  DATA_W  port 0 read data.
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- lock_err  out  1  one-cycle pulse on forced lock release.
- busy  out  1  high while a lock is held (state OWN0/OWN1).

Behaviour:
- Reset is asynchronous and active-low:
  - all memory words 0x00; state IDLE; rr_last = 1 (port 0 wins the first tie); lock_cnt = 0.
  - gnt0/1, rvalid0/1, lock_err, busy = 0; rdata0/1 = 0x00.
- gnt_i is combinational from state, rr_last and req_i. At most one gnt per cycle. gnt_i never asserts without req_i.
- An access executes on the rising edge where req_i & gnt_i = 1:
  - write: mem[addr_i] <= wdata_i.
  - read: rdata_i <= mem[addr_i] and rvalid_i <= 1 on that edge, so data is visible the cycle after the grant. Latency is 1 cycle.
  - rvalid_i is a single-cycle pulse. rdata_i holds its value until the next read on that port.
- A requester holds req and its address/data stable until it sees gnt. A request without gnt is retried next cycle; nothing is dropped.
- State IDLE:
  - only one port requesting: that port is granted.
  - both requesting: grant goes to the port that is not rr_last.
  - after a granted access by port i, rr_last <= i.
  - granted access with lock_i = 1: next state OWN_i, lock_cnt <= 1.
- State OWN_i:
  - only port i can be granted; the other port's gnt = 0 regardless of its req.
  - granted access with lock_i = 0: return to IDLE, rr_last <= i.
  - each cycle in OWN_i: lock_cnt increments, whether or not port i requests.
  - when lock_cnt reaches MAX_LOCK: forced to IDLE, lock_err pulses, rr_last <= i. This happens on the same edge even if port i's access that cycle is also granted; that access still completes.
- busy = 1 exactly in OWN0/OWN1.
- Read-after-write by the same or the other port on consecutive cycles returns the new data. There is no same-cycle collision, since only one grant exists per cycle.
- Addresses are ADDR_W wide and cover DEPTH exactly, so no out-of-range case exists.
- Reset asserted mid-lock or mid-read: immediate return to the reset values above; pending rvalid is cancelled.
- lock_i on a read or a write is legal. lock_i without req_i has no effect.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W, DATA_W, DEPTH.
  - arbiter state enum {ARB_IDLE, ARB_OWN0, ARB_OWN1}.
  - port index constants PORT_CORE = 0, PORT_LOAD = 1.
- One sub-module, mem_array_16x8: single-port synchronous-write, registered-read storage with async clear. The arbiter contains the FSM, round-robin logic, lock counter and the grant/rvalid steering.

Test Plan:
- Reset then port 1 write, port 0 read:
  - rst_n low 2 cycles, then port 1 writes 0x3C to addr 5 → gnt1 = 1 that cycle.
  - next cycle port 0 reads addr 5 → rvalid0 pulses one cycle later with rdata0 = 0x3C.
- Round-robin with both ports requesting:
  - both read addr 0 continuously for 4 cycles after reset → grants alternate 0, 1, 0, 1.
  - each rvalid arrives one cycle after its own grant.
- Core read-modify-write under lock:
  - port 0 reads addr 7 (value 0x21) with lock0 = 1, then writes 0x42 with lock0 = 0; port 1 requests throughout → gnt1 = 0 for both cycles, busy = 1 for one cycle.
  - port 1 granted next; its read of addr 7 returns 0x42.
- Forced release:
  - port 0 locks, then drops req0 while holding lock0 = 1; port 1 requesting → after MAX_LOCK = 4 cycles lock_err pulses once.
  - gnt1 = 1 the following cycle.
- Reset mid-lock:
  - assert rst_n low while in OWN0 with a read in flight → busy, gnt0/1, rvalid0/1 = 0 immediately.
  - after release, reading addr 5 returns 0x00.
- Request hold: port 1 requests while port 0 is locked for 2 cycles → port 1's address/data are accepted unchanged on the first cycle after the lock releases, and no access is lost.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: memory geometry, arbiter state encoding and
// requester port indices.
package cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

endpackage

// File: rtl/mem_array_16x8.sv
// Unified program/data storage: one access per cycle, synchronous write,
// registered read that holds its value between reads, async clear.
module mem_array_16x8 #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int DEPTH  = cpu_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of the unified memory, with a bounded
// ownership lock so core read-modify-write sequences are not interleaved.
module mem_port_arbiter #(
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int DEPTH    = cpu_pkg::DEPTH,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              lock_err,
    output logic              busy
);

    import cpu_pkg::arb_state_e;
    import cpu_pkg::ARB_IDLE;
    import cpu_pkg::ARB_OWN0;
    import cpu_pkg::ARB_OWN1;
    import cpu_pkg::PORT_CORE;
    import cpu_pkg::PORT_LOAD;

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e        state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_hold_q, rdata1_hold_q;

    logic              gnt0_raw, gnt1_raw;
    logic              lock_expired;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    // In IDLE a tie goes to the port that did not win last; an owner excludes the other port.
    always_comb begin
        gnt0_raw = 1'b0;
        gnt1_raw = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (req0 && req1) begin
                    if (rr_last_q == PORT_LOAD) begin
                        gnt0_raw = 1'b1;
                    end else begin
                        gnt1_raw = 1'b1;
                    end
                end else begin
                    gnt0_raw = req0;
                    gnt1_raw = req1;
                end
            end
            ARB_OWN0: gnt0_raw = req0;
            ARB_OWN1: gnt1_raw = req1;
            default:  ;
        endcase
    end

    // Grants are masked while reset is held so nothing appears to be accepted.
    assign gnt0 = gnt0_raw & rst_n;
    assign gnt1 = gnt1_raw & rst_n;

    assign lock_expired = (state_q != ARB_IDLE) && (lock_cnt_q == CNT_W'(MAX_LOCK));
    assign lock_err     = lock_expired;
    assign busy         = (state_q != ARB_IDLE);

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (gnt0) begin
                    rr_last_d = PORT_CORE;
                    if (lock0) begin
                        state_d    = ARB_OWN0;
                        lock_cnt_d = CNT_W'(1);
                    end
                end else if (gnt1) begin
                    rr_last_d = PORT_LOAD;
                    if (lock1) begin
                        state_d    = ARB_OWN1;
                        lock_cnt_d = CNT_W'(1);
                    end
                end
            end
            ARB_OWN0: begin
                if (lock_expired || (gnt0 && !lock0)) begin
                    state_d    = ARB_IDLE;
                    rr_last_d  = PORT_CORE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end
            ARB_OWN1: begin
                if (lock_expired || (gnt1 && !lock1)) begin
                    state_d    = ARB_IDLE;
                    rr_last_d  = PORT_LOAD;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            rr_last_q  <= PORT_LOAD;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign mem_en    = gnt0 | gnt1;
    assign mem_we    = gnt0 ? we0    : we1;
    assign mem_addr  = gnt0 ? addr0  : addr1;
    assign mem_wdata = gnt0 ? wdata0 : wdata1;

    mem_array_16x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    // The array's read register is shared, so each port latches its own copy
    // on its rvalid cycle to keep rdata stable until its next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            rdata0_hold_q <= '0;
            rdata1_hold_q <= '0;
        end else begin
            rvalid0_q <= gnt0 & ~we0;
            rvalid1_q <= gnt1 & ~we1;
            if (rvalid0_q) begin
                rdata0_hold_q <= mem_rdata;
            end
            if (rvalid1_q) begin
                rdata1_hold_q <= mem_rdata;
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rvalid0_q ? mem_rdata : rdata0_hold_q;
    assign rdata1  = rvalid1_q ? mem_rdata : rdata1_hold_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table for the scenario walk-through,
// then randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int MAX_LOCK = 4;
    localparam int N_RAND   = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
    logic [3:0] addr0 = '0;
    logic [7:0] wdata0 = '0;
    logic       req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [3:0] addr1 = '0;
    logic [7:0] wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, lock_err, busy;
    logic [7:0] rdata0, rdata1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .lock_err(lock_err), .busy(busy)
    );

    // c0/c1 = {req, we, lock}; eg = {gnt0, gnt1, busy, lock_err}; erv = {rvalid0, rvalid1}
    typedef struct {
        bit       rst;
        bit [2:0] c0;
        bit [3:0] a0;
        bit [7:0] d0;
        bit [2:0] c1;
        bit [3:0] a1;
        bit [7:0] d1;
        bit [3:0] eg;
        bit [1:0] erv;
        bit [7:0] erd0;
        bit [7:0] erd1;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit rst, input bit [2:0] c0, input bit [3:0] a0, input bit [7:0] d0,
                       input bit [2:0] c1, input bit [3:0] a1, input bit [7:0] d1,
                       input bit [3:0] eg, input bit [1:0] erv, input bit [7:0] erd0,
                       input bit [7:0] erd1);
        vec_t v;
        v.rst = rst; v.c0 = c0; v.a0 = a0; v.d0 = d0; v.c1 = c1; v.a1 = a1; v.d1 = d1;
        v.eg = eg; v.erv = erv; v.erd0 = erd0; v.erd1 = erd1;
        tv.push_back(v);
    endtask

    // Reference model: memory contents, current owner (-1 = none), last winner,
    // cycles the current owner has held the lock, and per-port read results.
    bit [7:0] mem_m [16];
    int       owner, last, held;
    bit       rv_m [2];
    bit [7:0] rd_m [2];
    bit       pend [2];
    bit       pwe [2];
    bit       plk [2];
    bit [3:0] pad [2];
    bit [7:0] pwd [2];

    initial begin
        // ---------------- directed table ----------------
        //  rst c0      a0    d0     c1      a1    d1     eg       erv    rd0    rd1
        add(1, 3'b000, 4'h0, 8'h00, 3'b000, 4'h0, 8'h00, 4'b0000, 2'b00, 8'h00, 8'h00);
        add(1, 3'b000, 4'h0, 8'h00, 3'b000, 4'h0, 8'h00, 4'b0000, 2'b00, 8'h00, 8'h00);
        // port 1 writes 0x3C to 5, port 0 reads it back
        add(0, 3'b000, 4'h0, 8'h00, 3'b110, 4'h5, 8'h3C, 4'b0100, 2'b00, 8'h00, 8'h00);
        add(0, 3'b100, 4'h5, 8'h00, 3'b000, 4'h0, 8'h00, 4'b1000, 2'b00, 8'h00, 8'h00);
        add(0, 3'b000, 4'h0, 8'h00, 3'b000, 4'h0, 8'h00, 4'b0000, 2'b10, 8'h3C, 8'h00);
        add(0, 3'b000, 4'h0, 8'h00, 3'b000, 4'h0, 8'h00, 4'b0000, 2'b00, 8'h3C, 8'h00);
        // reset, then both read addr 0: grants 0,1,0,1
        add(1, 3'b000, 4'h0, 8'h00, 3'b000, 4'h0, 8'h00, 4'b0000, 2'b00, 8'h00, 8'h00);
        add(1, 3'b000, 4'h0, 8'h00, 3'b000, 4'h0, 8'h00, 4'b0000, 2'b00, 8'h00, 8'h00);
        add(0, 3'b100, 4'h0, 8'h00, 3'b100, 4'h0, 8'h00, 4'b1000, 2'b00, 8'h00, 8'h00);
        add(0, 3'b100, 4'h0, 8'h00, 3'b100, 4'h0, 8'h00, 4'b0100, 2'b10, 8'h00, 8'h00);
        add(0, 3'b100, 4'h0, 8'h00, 3'b100, 4'h0, 8'h00, 4'b1000, 2'b01, 8'h00, 8'h00);
        add(0, 3'b100, 4'h0, 8'h00, 3'b100, 4'h0, 8'h00, 4'b0100, 2'b10, 8'h00, 8'h00);
        add(0, 3'b000, 4'h0, 8'h00, 3'b000, 4'h0, 8'h00, 4'b0000, 2'b01, 8'h00, 8'h00);
        // locked read-modify-write of addr 7 while port 1 keeps asking
        add(0, 3'b000, 4'h0, 8'h00, 3'b110, 4'h7, 8'h21, 4'b0100, 2'b00, 8'h00, 8'h00);
        add(0, 3'b101, 4'h7, 8'h00, 3'b100, 4'h7, 8'h00, 4'b1000, 2'b00, 8'h00, 8'h00);
        add(0, 3'b110, 4'h7, 8'h42, 3'b100, 4'h7, 8'h00, 4'b1010, 2'b10, 8'h21, 8'h00);
        add(0, 3'b000, 4'h0, 8'h00, 3'b100, 4'h7, 8'h00, 4'b0100, 2'b00, 8'h21, 8'h00);
        add(0, 3'b000, 4'h0, 8'h00, 3'b000, 4'h0, 8'h00, 4'b0000, 2'b01, 8'h21, 8'h42);
        // forced release: owner idles with lock0 held
        add(0, 3'b101, 4'h7, 8'h00, 3'b110, 4'h3, 8'h99, 4'b1000, 2'b00, 8'h21, 8'h42);
        add(0, 3'b001, 4'h0, 8'h00, 3'b110, 4'h3, 8'h99, 4'b0010, 2'b10, 8'h42, 8'h42);
        add(0, 3'b001, 4'h0, 8'h00, 3'b110, 4'h3, 8'h99, 4'b0010, 2'b00, 8'h42, 8'h42);
        add(0, 3'b001, 4'h0, 8'h00, 3'b110, 4'h3, 8'h99, 4'b0010, 2'b00, 8'h42, 8'h42);
        add(0, 3'b001, 4'h0, 8'h00, 3'b110, 4'h3, 8'h99, 4'b0011, 2'b00, 8'h42, 8'h42);
        add(0, 3'b000, 4'h0, 8'h00, 3'b110, 4'h3, 8'h99, 4'b0100, 2'b00, 8'h42, 8'h42);
        add(0, 3'b000, 4'h0, 8'h00, 3'b100, 4'h3, 8'h00, 4'b0100, 2'b00, 8'h42, 8'h42);
        add(0, 3'b000, 4'h0, 8'h00, 3'b000, 4'h0, 8'h00, 4'b0000, 2'b01, 8'h42, 8'h99);
        // port 1 write held across a two-cycle lock
        add(0, 3'b101, 4'h3, 8'h00, 3'b110, 4'h9, 8'h5A, 4'b1000, 2'b00, 8'h42, 8'h99);
        add(0, 3'b101, 4'h3, 8'h00, 3'b110, 4'h9, 8'h5A, 4'b1010, 2'b10, 8'h99, 8'h99);
        add(0, 3'b100, 4'h7, 8'h00, 3'b110, 4'h9, 8'h5A, 4'b1010, 2'b10, 8'h99, 8'h99);
        add(0, 3'b000, 4'h0, 8'h00, 3'b110, 4'h9, 8'h5A, 4'b0100, 2'b10, 8'h42, 8'h99);
        add(0, 3'b100, 4'h9, 8'h00, 3'b100, 4'h9, 8'h00, 4'b1000, 2'b00, 8'h42, 8'h99);
        add(0, 3'b000, 4'h0, 8'h00, 3'b100, 4'h9, 8'h00, 4'b0100, 2'b10, 8'h5A, 8'h99);
        add(0, 3'b000, 4'h0, 8'h00, 3'b000, 4'h0, 8'h00, 4'b0000, 2'b01, 8'h5A, 8'h5A);
        // reset while locked with a read in flight, then addr 5 reads back cleared
        add(0, 3'b000, 4'h0, 8'h00, 3'b110, 4'h5, 8'h77, 4'b0100, 2'b00, 8'h5A, 8'h5A);
        add(0, 3'b101, 4'h5, 8'h00, 3'b000, 4'h0, 8'h00, 4'b1000, 2'b00, 8'h5A, 8'h5A);
        add(1, 3'b101, 4'h9, 8'h00, 3'b100, 4'h9, 8'h00, 4'b0000, 2'b00, 8'h00, 8'h00);
        add(1, 3'b000, 4'h0, 8'h00, 3'b000, 4'h0, 8'h00, 4'b0000, 2'b00, 8'h00, 8'h00);
        add(0, 3'b100, 4'h5, 8'h00, 3'b000, 4'h0, 8'h00, 4'b1000, 2'b00, 8'h00, 8'h00);
        add(0, 3'b000, 4'h0, 8'h00, 3'b000, 4'h0, 8'h00, 4'b0000, 2'b10, 8'h00, 8'h00);

        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk); #1;
            rst_n = ~tv[i].rst;
            {req0, we0, lock0} = tv[i].c0; addr0 = tv[i].a0; wdata0 = tv[i].d0;
            {req1, we1, lock1} = tv[i].c1; addr1 = tv[i].a1; wdata1 = tv[i].d1;
            #4;
            check($sformatf("row%0d gnt0/gnt1/busy/lock_err", i), 32'({gnt0, gnt1, busy, lock_err}), 32'(tv[i].eg));
            check($sformatf("row%0d rvalid0/rvalid1", i), 32'({rvalid0, rvalid1}), 32'(tv[i].erv));
            check($sformatf("row%0d rdata0", i), 32'(rdata0), 32'(tv[i].erd0));
            check($sformatf("row%0d rdata1", i), 32'(rdata1), 32'(tv[i].erd1));
        end

        // ---------------- randomized traffic vs reference model ----------------
        @(posedge clk); #1;
        rst_n = 1'b0;
        {req0, we0, lock0, req1, we1, lock1} = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) mem_m[k] = 8'h00;
        owner = -1; last = 1; held = 0;
        for (int p = 0; p < 2; p++) begin
            rv_m[p] = 1'b0; rd_m[p] = 8'h00; pend[p] = 1'b0;
        end

        for (int cyc = 0; cyc < N_RAND; cyc++) begin
            int  g;
            bit  expired;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    pend[p] = 1'($urandom_range(0, 1));
                    pwe[p]  = 1'($urandom_range(0, 1));
                    plk[p]  = pend[p] ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
                    pad[p]  = 4'($urandom_range(0, 15));
                    pwd[p]  = 8'($urandom_range(0, 255));
                end
            end
            req0 = pend[0]; we0 = pwe[0]; lock0 = plk[0]; addr0 = pad[0]; wdata0 = pwd[0];
            req1 = pend[1]; we1 = pwe[1]; lock1 = plk[1]; addr1 = pad[1]; wdata1 = pwd[1];

            if (owner >= 0)              g = pend[owner] ? owner : -1;
            else if (pend[0] && pend[1]) g = 1 - last;
            else if (pend[0])            g = 0;
            else if (pend[1])            g = 1;
            else                         g = -1;
            expired = (owner >= 0) && (held == MAX_LOCK);

            #4;
            check($sformatf("rand%0d gnt0/gnt1/busy/lock_err", cyc), 32'({gnt0, gnt1, busy, lock_err}),
                  32'({g == 0, g == 1, owner >= 0, expired}));
            check($sformatf("rand%0d rvalid0/rvalid1", cyc), 32'({rvalid0, rvalid1}), 32'({rv_m[0], rv_m[1]}));
            check($sformatf("rand%0d rdata0", cyc), 32'(rdata0), 32'(rd_m[0]));
            check($sformatf("rand%0d rdata1", cyc), 32'(rdata1), 32'(rd_m[1]));

            rv_m[0] = 1'b0; rv_m[1] = 1'b0;
            if (g >= 0) begin
                if (pwe[g]) mem_m[pad[g]] = pwd[g];
                else begin
                    rv_m[g] = 1'b1;
                    rd_m[g] = mem_m[pad[g]];
                end
                pend[g] = 1'b0;
            end
            if (owner >= 0) begin
                if (expired || (g == owner && !plk[owner])) begin
                    last = owner; owner = -1; held = 0;
                end else begin
                    held++;
                end
            end else if (g >= 0) begin
                last = g;
                if (plk[g]) begin
                    owner = g; held = 1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
